axi_wr_scheduler: RTL and testbench

- Control-only scheduler that shares one AXI4 write path (AW/W/B) between NumSrc requesters, e.g. I$, bypass and D$ write-back ports.
- Performs round-robin AW arbitration and records grant order so W beats follow AW order, since AXI4 has no WID.
- Routes B responses to their source and enforces a per-source outstanding-write credit limit.
- The external datapath muxes payloads using aw_sel_o and w_sel_o. This block never touches address or data bits.

---
 rtl/axi_wr_scheduler.sv | 167 ++++++++++++++++
 tb/tb_axi_wr_scheduler.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_wr_scheduler.sv
// Shares one AXI4 AW/W/B path between NumSrc requesters: round-robin AW grant, in-order W ownership,
// B routing and per-source outstanding credit. AW grant is combinational and held until accepted.
module axi_wr_scheduler #(
  parameter int NumSrc     = 3,
  parameter int OrderDepth = 4,
  parameter int MaxOutst   = 4,
  localparam int SelW      = (NumSrc > 1) ? $clog2(NumSrc) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NumSrc-1:0] src_aw_valid_i,
  output logic [NumSrc-1:0] src_aw_ready_o,
  output logic              aw_valid_o,
  input  logic              aw_ready_i,
  output logic [SelW-1:0]   aw_sel_o,
  input  logic [NumSrc-1:0] src_w_valid_i,
  input  logic [NumSrc-1:0] src_w_last_i,
  output logic [NumSrc-1:0] src_w_ready_o,
  output logic              w_valid_o,
  input  logic              w_ready_i,
  output logic [SelW-1:0]   w_sel_o,
  input  logic              b_valid_i,
  input  logic [SelW-1:0]   b_src_i,
  output logic              b_ready_o,
  output logic [NumSrc-1:0] src_b_valid_o,
  input  logic [NumSrc-1:0] src_b_ready_i,
  output logic              busy_o,
  output logic              err_o
);

  localparam int CntW = $clog2(MaxOutst + 1);
  localparam int PtrW = $clog2(OrderDepth);
  localparam int OccW = PtrW + 1;

  logic [SelW-1:0] rr_q, rr_d;
  logic            lock_q, lock_d;
  logic [SelW-1:0] lock_sel_q, lock_sel_d;
  logic [SelW-1:0] fifo_q [OrderDepth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [OccW-1:0] occ_q, occ_d;
  logic [CntW-1:0] cnt_q [NumSrc];
  logic            err_q, err_d;

  logic              fifo_full, fifo_empty;
  logic              aw_vld, aw_hs;
  logic [SelW-1:0]   aw_sel, idx;
  logic              w_own, w_vld, w_pop, push_eff, pop_eff;
  logic [SelW-1:0]   w_sel;
  logic [NumSrc-1:0] w_rdy_vec, b_vld_vec, inc_vec, dec_vec;
  logic              b_in_range, b_rdy, b_hs, any_cnt;

  assign fifo_full  = (occ_q == OccW'(OrderDepth));
  assign fifo_empty = (occ_q == '0);

  // Downward scan so the smallest offset from rr_q is the last (winning) assignment.
  always_comb begin
    aw_vld = 1'b0;
    aw_sel = '0;
    idx    = '0;
    if (lock_q) begin
      aw_vld = 1'b1;
      aw_sel = lock_sel_q;
    end else if (!fifo_full) begin
      for (int k = NumSrc - 1; k >= 0; k--) begin
        idx = SelW'((int'(rr_q) + k) % NumSrc);
        if (src_aw_valid_i[idx] && (cnt_q[idx] < CntW'(MaxOutst))) begin
          aw_vld = 1'b1;
          aw_sel = idx;
        end
      end
    end
  end

  assign aw_hs      = aw_vld & aw_ready_i;
  assign lock_d     = aw_vld & ~aw_ready_i;
  assign lock_sel_d = aw_sel;
  assign rr_d       = !aw_hs ? rr_q :
                      (int'(aw_sel) == NumSrc - 1) ? '0 : aw_sel + 1'b1;

  // An empty FIFO lets the write being granted this cycle own W immediately.
  always_comb begin
    w_own     = 1'b0;
    w_sel     = '0;
    w_rdy_vec = '0;
    if (!fifo_empty) begin
      w_own = 1'b1;
      w_sel = fifo_q[rd_ptr_q];
    end else if (aw_hs) begin
      w_own = 1'b1;
      w_sel = aw_sel;
    end
    w_vld = w_own & src_w_valid_i[w_sel];
    if (w_own) w_rdy_vec[w_sel] = w_ready_i;
    w_pop = w_vld & w_ready_i & src_w_last_i[w_sel];
  end

  assign push_eff = aw_hs & ~(fifo_empty & w_pop);
  assign pop_eff  = w_pop & ~fifo_empty;
  assign occ_d    = occ_q + OccW'(push_eff) - OccW'(pop_eff);

  always_comb begin
    b_in_range = (int'(b_src_i) < NumSrc);
    b_vld_vec  = '0;
    b_rdy      = 1'b1;
    if (b_in_range) begin
      b_vld_vec[b_src_i] = b_valid_i;
      b_rdy              = src_b_ready_i[b_src_i];
    end
    b_hs  = b_valid_i & b_rdy;
    err_d = err_q;
    if (b_hs && (!b_in_range || (cnt_q[b_src_i] == '0))) err_d = 1'b1;
  end

  always_comb begin
    any_cnt = 1'b0;
    inc_vec = '0;
    dec_vec = '0;
    for (int i = 0; i < NumSrc; i++) begin
      inc_vec[i] = aw_hs && (aw_sel == SelW'(i));
      dec_vec[i] = b_hs && b_in_range && (b_src_i == SelW'(i));
      if (cnt_q[i] != '0) any_cnt = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_sel_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < OrderDepth; i++) fifo_q[i] <= '0;
      for (int i = 0; i < NumSrc; i++) cnt_q[i] <= '0;
    end else begin
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      lock_sel_q <= lock_sel_d;
      occ_q      <= occ_d;
      err_q      <= err_d;
      if (push_eff) begin
        fifo_q[wr_ptr_q] <= aw_sel;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (pop_eff) rd_ptr_q <= rd_ptr_q + 1'b1;
      // A simultaneous grant and response for one source cancel out.
      for (int i = 0; i < NumSrc; i++) begin
        if (inc_vec[i] && !dec_vec[i]) cnt_q[i] <= cnt_q[i] + 1'b1;
        else if (dec_vec[i] && !inc_vec[i] && (cnt_q[i] != '0)) cnt_q[i] <= cnt_q[i] - 1'b1;
      end
    end
  end

  // Combinational paths are gated so every output reads 0 while reset is held.
  assign aw_valid_o     = rst_ni & aw_vld;
  assign aw_sel_o       = rst_ni ? aw_sel : '0;
  assign src_aw_ready_o = (rst_ni && aw_hs) ? (NumSrc'(1) << aw_sel) : '0;
  assign w_valid_o      = rst_ni & w_vld;
  assign w_sel_o        = rst_ni ? w_sel : '0;
  assign src_w_ready_o  = rst_ni ? w_rdy_vec : '0;
  assign src_b_valid_o  = rst_ni ? b_vld_vec : '0;
  assign b_ready_o      = rst_ni & b_rdy;
  assign busy_o         = rst_ni & (~fifo_empty | any_cnt | aw_vld);
  assign err_o          = rst_ni & err_q;

endmodule

// File: tb/tb_axi_wr_scheduler.sv
// Bench for axi_wr_scheduler: directed scenarios plus random traffic against a queue-based reference.
module tb_axi_wr_scheduler;
  localparam int N = 3;
  localparam int D = 4;
  localparam int M = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] aw_v = '0, aw_rdy_o, w_v = '0, w_last = '0, w_rdy_o, b_vld_o, b_rdy_i = '0;
  logic       aw_vo, aw_ri = 1'b0, w_vo, w_ri = 1'b0, b_vi = 1'b0, b_ro, busy, err;
  logic [1:0] aw_sel, w_sel, b_src = '0;

  axi_wr_scheduler #(.NumSrc(N), .OrderDepth(D), .MaxOutst(M)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .src_aw_valid_i(aw_v), .src_aw_ready_o(aw_rdy_o), .aw_valid_o(aw_vo), .aw_ready_i(aw_ri),
    .aw_sel_o(aw_sel), .src_w_valid_i(w_v), .src_w_last_i(w_last), .src_w_ready_o(w_rdy_o),
    .w_valid_o(w_vo), .w_ready_i(w_ri), .w_sel_o(w_sel), .b_valid_i(b_vi), .b_src_i(b_src),
    .b_ready_o(b_ro), .src_b_valid_o(b_vld_o), .src_b_ready_i(b_rdy_i), .busy_o(busy), .err_o(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference state: next RR start, pending (unaccepted) grant, W-order queue, per-source credits.
  int m_rr, m_lock, m_lsel, m_cnt[N], m_err;
  int m_q[$];
  int e_av, e_as, e_ahs, e_own, e_ws, e_wv, e_pop, e_bhs;

  task automatic model_clear();
    m_rr = 0; m_lock = 0; m_lsel = 0; m_err = 0;
    m_q.delete();
    for (int s = 0; s < N; s++) m_cnt[s] = 0;
  endtask

  task automatic eval();
    int busy_e, bv_e, br_e;
    #1;
    if (!rst_n) begin
      model_clear();
      e_av = 0; e_as = 0; e_ahs = 0; e_own = 0; e_ws = 0; e_wv = 0; e_pop = 0; e_bhs = 0;
      check_eq("rst_out", {aw_vo, aw_sel, aw_rdy_o, w_vo, w_sel, w_rdy_o, b_vld_o, b_ro, busy, err}, 0);
      return;
    end
    e_av = 0; e_as = 0;
    if (m_lock != 0) begin
      e_av = 1; e_as = m_lsel;
    end else if (m_q.size() < D) begin
      for (int k = 0; k < N && e_av == 0; k++) begin
        int s = (m_rr + k) % N;
        if (aw_v[s] && m_cnt[s] < M) begin e_av = 1; e_as = s; end
      end
    end
    e_ahs = e_av & int'(aw_ri);
    e_own = 0; e_ws = 0;
    if (m_q.size() > 0) begin e_own = 1; e_ws = m_q[0]; end
    else if (e_ahs != 0) begin e_own = 1; e_ws = e_as; end
    e_wv  = (e_own != 0) ? int'(w_v[e_ws]) : 0;
    e_pop = e_wv & int'(w_ri) & int'(w_last[e_ws]);
    bv_e = 0; br_e = 1;
    if (b_src < N) begin bv_e = int'(b_vi) << b_src; br_e = int'(b_rdy_i[b_src]); end
    e_bhs = int'(b_vi) & br_e;
    busy_e = (m_q.size() > 0 || e_av != 0) ? 1 : 0;
    for (int s = 0; s < N; s++) if (m_cnt[s] != 0) busy_e = 1;
    check_eq("aw_valid", aw_vo, e_av);
    check_eq("aw_sel", aw_sel, e_as);
    check_eq("src_aw_ready", aw_rdy_o, (e_ahs != 0) ? (1 << e_as) : 0);
    check_eq("w_valid", w_vo, e_wv);
    check_eq("w_sel", w_sel, e_ws);
    check_eq("src_w_ready", w_rdy_o, (e_own != 0) ? (int'(w_ri) << e_ws) : 0);
    check_eq("src_b_valid", b_vld_o, bv_e);
    check_eq("b_ready", b_ro, br_e);
    check_eq("busy", busy, busy_e);
    check_eq("err", err, m_err);
  endtask

  task automatic adv();
    if (rst_n) begin
      if (e_ahs != 0) begin
        m_q.push_back(e_as);
        m_rr = (e_as + 1) % N;
        m_lock = 0;
      end else if (e_av != 0) begin
        m_lock = 1; m_lsel = e_as;
      end
      if (e_pop != 0) void'(m_q.pop_front());
      if (e_bhs != 0 && b_src >= N) m_err = 1;
      for (int s = 0; s < N; s++) begin
        bit inc = (e_ahs != 0) && (e_as == s);
        bit dec = (e_bhs != 0) && (b_src == s);
        if (dec && m_cnt[s] == 0) m_err = 1;
        if (inc && !dec) m_cnt[s]++;
        else if (dec && !inc && m_cnt[s] > 0) m_cnt[s]--;
      end
    end
    @(negedge clk);
  endtask

  task automatic cyc();
    eval();
    adv();
  endtask

  task automatic idle_inputs();
    aw_v = '0; aw_ri = 1'b1; w_v = '0; w_last = '0; w_ri = 1'b1; b_vi = 1'b0; b_src = '0; b_rdy_i = '1;
  endtask

  // Flush pending W ownership, then return every outstanding credit.
  task automatic drain();
    idle_inputs();
    w_v = '1; w_last = '1;
    for (int i = 0; i <= D; i++) cyc();
    w_v = '0; w_last = '0;
    for (int i = 0; i < N * M + 2; i++) begin
      b_vi = 1'b0;
      for (int s = 0; s < N; s++) if (m_cnt[s] > 0 && !b_vi) begin b_vi = 1'b1; b_src = 2'(s); end
      cyc();
    end
    b_vi = 1'b0; b_src = '0;
  endtask

  initial begin
    int cand[$];
    model_clear();
    @(negedge clk);
    aw_v = '1; w_v = '1; aw_ri = 1'b1; w_ri = 1'b1; b_vi = 1'b1; b_rdy_i = '1;
    cyc();
    idle_inputs();
    cyc();
    rst_n = 1'b1;
    cyc();

    // Single write from src0 with fall-through W.
    aw_v = 3'b001; w_v = 3'b001; w_last = 3'b000;
    eval();
    check_eq("t1_aw_sel", {aw_vo, aw_sel}, 3'b100);
    check_eq("t1_w_ft", {w_vo, w_sel, w_rdy_o}, 6'b100001);
    adv();
    aw_v = '0; w_last = 3'b001;
    eval(); check_eq("t1_w_beat2", {w_vo, w_sel}, 3'b100); adv();
    w_v = '0; w_last = '0;
    eval(); check_eq("t1_busy_hold", {busy, w_vo}, 2'b10); adv();
    b_vi = 1'b1; b_src = 2'd0;
    eval(); check_eq("t1_b_route", {b_vld_o, b_ro}, 4'b0011); adv();
    b_vi = 1'b0;
    eval(); check_eq("t1_idle", busy, 0); adv();

    // Continuous requests from all sources rotate one grant per cycle.
    aw_v = '1; w_v = '1; w_last = '1;
    for (int k = 0; k < 6; k++) begin
      eval(); check_eq("t2_rr", aw_rdy_o, 1 << ((1 + k) % N)); adv();
    end
    drain();

    // A grant stalled by aw_ready stays put even when another source rises.
    aw_ri = 1'b0; aw_v = 3'b010;
    cyc();
    aw_v = 3'b011;
    for (int k = 0; k < 5; k++) begin
      eval(); check_eq("t3_lock", {aw_vo, aw_sel}, 3'b101); adv();
    end
    aw_ri = 1'b1;
    eval(); check_eq("t3_accept", aw_rdy_o, 3'b010); adv();
    aw_v = 3'b001;
    eval(); check_eq("t3_next", aw_rdy_o, 3'b001); adv();
    drain();

    // W ownership follows AW order; a full order FIFO blocks further grants.
    w_v = '0;
    aw_v = 3'b100; cyc();
    aw_v = 3'b001; cyc();
    aw_v = 3'b100; cyc();
    aw_v = 3'b010; cyc();
    aw_v = 3'b111;
    eval(); check_eq("t4_full_block", aw_vo, 0); adv();
    aw_v = '0; w_v = '1; w_last = '1;
    eval(); check_eq("t4_order0", w_sel, 2); adv();
    eval(); check_eq("t4_order1", w_sel, 0); adv();
    eval(); check_eq("t4_order2", w_sel, 2); adv();
    eval(); check_eq("t4_order3", w_sel, 1); adv();
    drain();

    // Credit limit for src1, B re-enables, AW+B in one cycle leaves the credit count alone.
    w_v = '1; w_last = '1; aw_v = 3'b010;
    for (int k = 0; k < M; k++) cyc();
    aw_v = 3'b011;
    eval(); check_eq("t5_stall_src1", aw_rdy_o, 3'b001); adv();
    aw_v = 3'b010; b_vi = 1'b1; b_src = 2'd1;
    eval(); check_eq("t5_still_full", aw_vo, 0); adv();
    eval(); check_eq("t5_aw_and_b", aw_rdy_o, 3'b010); adv();
    b_vi = 1'b0;
    eval(); check_eq("t5_refill", aw_rdy_o, 3'b010); adv();
    eval(); check_eq("t5_stall_again", aw_vo, 0); adv();
    drain();

    // Spurious B sets the sticky error; reset mid-burst clears everything.
    b_vi = 1'b1; b_src = 2'd1; b_rdy_i = 3'b010;
    eval(); check_eq("t6_err_pre", err, 0); adv();
    b_vi = 1'b0;
    for (int k = 0; k < 3; k++) begin
      eval(); check_eq("t6_err_sticky", err, 1); adv();
    end
    b_vi = 1'b1; b_src = 2'd3;
    eval(); check_eq("t6_oor_drop", {b_vld_o, b_ro}, 4'b0001); adv();
    b_vi = 1'b0; aw_v = 3'b001; w_v = 3'b001; w_last = '0;
    cyc();
    aw_v = '0;
    cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    eval(); check_eq("t6_no_owner", {w_vo, w_rdy_o, err, busy}, 0); adv();
    drain();

    // Random traffic against the reference.
    for (int c = 0; c < 1500; c++) begin
      aw_v   = 3'($urandom_range(0, 7));
      aw_ri  = ($urandom_range(0, 3) != 0);
      w_v    = 3'($urandom_range(0, 7));
      w_last = 3'($urandom_range(0, 7));
      w_ri   = ($urandom_range(0, 3) != 0);
      b_rdy_i = 3'($urandom_range(0, 7));
      cand.delete();
      for (int s = 0; s < N; s++) if (m_cnt[s] > 0) cand.push_back(s);
      b_vi = 1'b0; b_src = 2'($urandom_range(0, 2));
      if (cand.size() > 0 && $urandom_range(0, 1) != 0) begin
        b_vi = 1'b1;
        b_src = 2'(cand[$urandom_range(0, cand.size() - 1)]);
      end
      cyc();
    end
    drain();
    eval(); check_eq("final_idle", {busy, err}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
